// File: rtl/seg7_arb_pkg.sv
// seg7_arb_pkg
// Shared definitions for the 7-segment write arbiter: the FSM state
// encoding, byte offsets of the display registers relative to the base
// address, the requester count, and a helper that turns a requester index
// into its one-hot acknowledge vector.
package seg7_arb_pkg;

   localparam int NUM_REQ = 2;

   // High byte lives at the base address, low byte right after it.
   localparam logic [7:0] HI_OFFSET = 8'd0;
   localparam logic [7:0] LO_OFFSET = 8'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_HI = 2'd1,
      WR_LO = 2'd2
   } arb_state_t;

   function automatic logic [NUM_REQ-1:0] ack_onehot(input logic idx);
      ack_onehot = idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/seg7_write_arbiter_rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin picker. The pointer register that
// remembers the previous winner lives in the parent; this block only
// decides who wins this cycle.
// Ports:
//   req   in  2  eligible requesters (already masked by the parent)
//   last  in  1  index of the previous winner
//   grant out 1  index of the winner this cycle
//   valid out 1  at least one requester is eligible
module rr_pick2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic       grant,
   output logic       valid
);

   // A lone requester always wins; on a tie the one that did not win last
   // time gets the slot.
   always_comb begin
      grant = 1'b0;
      valid = |req;
      case (req)
         2'b01:   grant = 1'b0;
         2'b10:   grant = 1'b1;
         2'b11:   grant = ~last;
         default: grant = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_write_arbiter.sv
// seg7_write_arbiter
// Shares the memory-mapped 7-segment display (high byte at Seg7BaseAddress,
// low byte at Seg7BaseAddress+1) between two hardware requesters. The
// winner's 16-bit value is latched at grant and written one byte per cycle
// whenever the bus is free. A shadow copy of the displayed value lets
// unchanged bytes be skipped.
// Ports:
//   CLK        in  1   system clock, rising edge
//   RESET      in  1   synchronous active-high reset
//   REQ        in  2   per-requester level request, held until ACK
//   VALUE0     in  16  requester 0 value, sampled at grant
//   VALUE1     in  16  requester 1 value, sampled at grant
//   ACK        out 2   one-cycle completion pulse per requester
//   INVALIDATE in  1   pulse: display was written by someone else
//   BUS_FREE   in  1   this block may write this cycle
//   BUS_ADDR   out 8   write address
//   BUS_DATA   out 8   write data
//   BUS_WE     out 1   one-cycle write strobe per byte
//   BUSY       out 1   transaction in progress
module seg7_write_arbiter
   import seg7_arb_pkg::*;
#(
   parameter logic [7:0] Seg7BaseAddress = 8'hD0,
   parameter bit         SKIP_UNCHANGED  = 1'b1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [1:0]  REQ,
   input  logic [15:0] VALUE0,
   input  logic [15:0] VALUE1,
   output logic [1:0]  ACK,
   input  logic        INVALIDATE,
   input  logic        BUS_FREE,
   output logic [7:0]  BUS_ADDR,
   output logic [7:0]  BUS_DATA,
   output logic        BUS_WE,
   output logic        BUSY
);

   arb_state_t  state;
   logic [15:0] hold;
   logic        winner;
   logic        last;
   logic        need_lo_q;
   logic        both_q;
   logic [15:0] shadow;
   logic        shadow_valid;

   logic [1:0]  masked_req;
   logic        pick_idx;
   logic        pick_valid;
   logic [15:0] pick_value;
   logic        need_hi;
   logic        need_lo;

   // A requester that is being acknowledged this cycle may still be holding
   // REQ, so it is kept out of the running for one edge.
   assign masked_req = REQ & ~ACK;

   rr_pick2 u_pick (
      .req   (masked_req),
      .last  (last),
      .grant (pick_idx),
      .valid (pick_valid)
   );

   // The write plan is decided once, at grant, from the candidate value and
   // the shadow as they are at that edge.
   assign pick_value = pick_idx ? VALUE1 : VALUE0;
   assign need_hi    = !SKIP_UNCHANGED || !shadow_valid || (pick_value[15:8] != shadow[15:8]);
   assign need_lo    = !SKIP_UNCHANGED || !shadow_valid || (pick_value[7:0]  != shadow[7:0]);

   assign BUSY = (state != IDLE);

   // Main FSM: grant, high-byte write, low-byte write. Strobe and ACK are
   // pulses; address and data keep their last driven values. The shadow is
   // only trusted again after a transaction that rewrote both bytes, and an
   // INVALIDATE on the same edge takes priority over that.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= IDLE;
         hold         <= 16'h0000;
         winner       <= 1'b0;
         last         <= 1'b1;
         need_lo_q    <= 1'b0;
         both_q       <= 1'b0;
         shadow       <= 16'h0000;
         shadow_valid <= 1'b0;
         ACK          <= 2'b00;
         BUS_ADDR     <= 8'h00;
         BUS_DATA     <= 8'h00;
         BUS_WE       <= 1'b0;
      end else begin
         ACK    <= 2'b00;
         BUS_WE <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_valid) begin
                  last      <= pick_idx;
                  winner    <= pick_idx;
                  hold      <= pick_value;
                  need_lo_q <= need_lo;
                  both_q    <= need_hi && need_lo;
                  if (need_hi) begin
                     state <= WR_HI;
                  end else if (need_lo) begin
                     state <= WR_LO;
                  end else begin
                     ACK <= ack_onehot(pick_idx);
                  end
               end
            end
            WR_HI: begin
               if (BUS_FREE) begin
                  BUS_WE        <= 1'b1;
                  BUS_ADDR      <= Seg7BaseAddress + HI_OFFSET;
                  BUS_DATA      <= hold[15:8];
                  shadow[15:8]  <= hold[15:8];
                  if (need_lo_q) begin
                     state <= WR_LO;
                  end else begin
                     ACK   <= ack_onehot(winner);
                     state <= IDLE;
                  end
               end
            end
            WR_LO: begin
               if (BUS_FREE) begin
                  BUS_WE      <= 1'b1;
                  BUS_ADDR    <= Seg7BaseAddress + LO_OFFSET;
                  BUS_DATA    <= hold[7:0];
                  shadow[7:0] <= hold[7:0];
                  ACK         <= ack_onehot(winner);
                  state       <= IDLE;
                  if (both_q) begin
                     shadow_valid <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
         if (INVALIDATE) begin
            shadow_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg7_write_arbiter.sv
// tb_seg7_write_arbiter
// Self-checking bench for seg7_write_arbiter. Expected bus writes are
// queued when a request is driven and popped by a monitor whenever BUS_WE
// is seen. A second instance with SKIP_UNCHANGED=0 has its own request
// line and is only exercised at the end.
module tb_seg7_write_arbiter;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic [1:0] ack;
   } wr_t;

   typedef struct {
      logic [1:0]  req;
      logic [15:0] v0;
      logic [15:0] v1;
      logic [1:0]  exp_ack;
      logic        wr_hi;
      logic        wr_lo;
      logic [7:0]  hi_data;
      logic [7:0]  lo_data;
      int          exp_lat;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [1:0]  REQ;
   logic [1:0]  req_ns;
   logic [15:0] VALUE0;
   logic [15:0] VALUE1;
   logic [1:0]  ACK;
   logic        INVALIDATE;
   logic        BUS_FREE;
   logic [7:0]  BUS_ADDR;
   logic [7:0]  BUS_DATA;
   logic        BUS_WE;
   logic        BUSY;
   logic [1:0]  ns_ack;
   logic [7:0]  ns_addr;
   logic [7:0]  ns_data;
   logic        ns_we;
   logic        ns_busy;

   wr_t  sb[$];
   wr_t  exp_item;
   int   tests = 0;
   int   failures = 0;
   logic prev_we = 1'b0;
   logic [7:0] prev_addr = 8'h00;

   vec_t vecs[5];
   vec_t v;
   logic [1:0] alt_exp[3];

   always #5 CLK = ~CLK;

   seg7_write_arbiter #(.Seg7BaseAddress(8'hD0), .SKIP_UNCHANGED(1'b1)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ        (REQ),
      .VALUE0     (VALUE0),
      .VALUE1     (VALUE1),
      .ACK        (ACK),
      .INVALIDATE (INVALIDATE),
      .BUS_FREE   (BUS_FREE),
      .BUS_ADDR   (BUS_ADDR),
      .BUS_DATA   (BUS_DATA),
      .BUS_WE     (BUS_WE),
      .BUSY       (BUSY)
   );

   seg7_write_arbiter #(.Seg7BaseAddress(8'hD0), .SKIP_UNCHANGED(1'b0)) dut_noskip (
      .CLK        (CLK),
      .RESET      (RESET),
      .REQ        (req_ns),
      .VALUE0     (VALUE0),
      .VALUE1     (VALUE1),
      .ACK        (ns_ack),
      .INVALIDATE (INVALIDATE),
      .BUS_FREE   (BUS_FREE),
      .BUS_ADDR   (ns_addr),
      .BUS_DATA   (ns_data),
      .BUS_WE     (ns_we),
      .BUSY       (ns_busy)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance to just after the next falling edge, away from the active edge
   // and after the write monitor has run.
   task automatic tick;
      @(negedge CLK);
      #1;
   endtask

   // Every observed write must match the next queued expectation, and the
   // strobe must never repeat on the same address.
   always @(negedge CLK) begin
      if (BUS_WE === 1'b1) begin
         if (sb.size() == 0) begin
            tests++;
            failures++;
            $display("[TB] FAIL unexpected_write: got addr %h data %h, required no write", BUS_ADDR, BUS_DATA);
         end else begin
            exp_item = sb.pop_front();
            checkOutput("bus_write", 32'({BUS_ADDR, BUS_DATA, ACK}), 32'(exp_item));
         end
         if (prev_we) begin
            checkOutput("we_not_repeated", 32'(prev_addr == BUS_ADDR), 32'd0);
         end
      end
      prev_we   = (BUS_WE === 1'b1);
      prev_addr = BUS_ADDR;
   end

   task automatic waitAck(input int budget, output logic [1:0] seen, output int cycles);
      seen   = 2'b00;
      cycles = 0;
      for (int c = 0; c < budget; c++) begin
         tick;
         cycles++;
         if (ACK != 2'b00) begin
            seen = ACK;
            break;
         end
      end
   endtask

   // One full transaction with BUS_FREE held high: queue its writes, raise
   // REQ, wait for ACK, then check ACK, latency and that all writes came out.
   task automatic applyStimulus(input vec_t vv, input string name);
      logic [1:0] seen;
      int cyc;
      tick;
      VALUE0 = vv.v0;
      VALUE1 = vv.v1;
      if (vv.wr_hi) sb.push_back(wr_t'{addr: 8'hD0, data: vv.hi_data, ack: (vv.wr_lo ? 2'b00 : vv.exp_ack)});
      if (vv.wr_lo) sb.push_back(wr_t'{addr: 8'hD1, data: vv.lo_data, ack: vv.exp_ack});
      REQ = vv.req;
      waitAck(12, seen, cyc);
      REQ = 2'b00;
      checkOutput({name, "_ack"}, 32'(seen), 32'(vv.exp_ack));
      checkOutput({name, "_latency"}, 32'(cyc), 32'(vv.exp_lat));
      checkOutput({name, "_sb_drained"}, 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   task automatic runNoSkip(input logic [15:0] value, input string name);
      logic [1:0] seen;
      int n_wr;
      logic [7:0] l_addr;
      logic [7:0] l_data;
      seen   = 2'b00;
      n_wr   = 0;
      l_addr = 8'h00;
      l_data = 8'h00;
      tick;
      VALUE0 = value;
      req_ns = 2'b01;
      for (int c = 0; c < 10; c++) begin
         tick;
         if (ns_we) begin
            n_wr++;
            l_addr = ns_addr;
            l_data = ns_data;
         end
         if (ns_ack != 2'b00) begin
            seen = ns_ack;
            break;
         end
      end
      req_ns = 2'b00;
      checkOutput({name, "_ack"}, 32'(seen), 32'h1);
      checkOutput({name, "_writes"}, 32'(n_wr), 32'd2);
      checkOutput({name, "_lo_write"}, 32'({l_addr, l_data}), 32'({8'hD1, value[7:0]}));
      checkOutput({name, "_busy"}, 32'(ns_busy), 32'd0);
   endtask

   initial begin
      logic [1:0] seen;
      int cyc;

      // req, v0, v1, ack, wr_hi, wr_lo, hi, lo, latency; shadow starts at 1234
      vecs[0] = '{2'b10, 16'h0000, 16'h1299, 2'b10, 1'b0, 1'b1, 8'h00, 8'h99, 2};
      vecs[1] = '{2'b10, 16'h0000, 16'h1299, 2'b10, 1'b0, 1'b0, 8'h00, 8'h00, 1};
      vecs[2] = '{2'b01, 16'h1256, 16'h0000, 2'b01, 1'b0, 1'b1, 8'h00, 8'h56, 2};
      vecs[3] = '{2'b01, 16'h3456, 16'h0000, 2'b01, 1'b1, 1'b0, 8'h34, 8'h00, 2};
      vecs[4] = '{2'b10, 16'h0000, 16'hABCD, 2'b10, 1'b1, 1'b1, 8'hAB, 8'hCD, 3};
      alt_exp[0] = 2'b01;
      alt_exp[1] = 2'b10;
      alt_exp[2] = 2'b01;

      RESET      = 1'b1;
      REQ        = 2'b00;
      req_ns     = 2'b00;
      VALUE0     = 16'h0000;
      VALUE1     = 16'h0000;
      INVALIDATE = 1'b0;
      BUS_FREE   = 1'b1;
      repeat (3) tick;
      checkOutput("reset_outputs", 32'({BUS_WE, BUS_ADDR, BUS_DATA, ACK, BUSY}), 32'd0);
      RESET = 1'b0;

      // Basic latency; VALUE0 changes right after grant and must be ignored.
      tick;
      VALUE0 = 16'h1234;
      sb.push_back(wr_t'{addr: 8'hD0, data: 8'h12, ack: 2'b00});
      sb.push_back(wr_t'{addr: 8'hD1, data: 8'h34, ack: 2'b01});
      REQ = 2'b01;
      tick;
      checkOutput("lat_grant", 32'({BUSY, BUS_WE}), 32'b10);
      VALUE0 = 16'hFFFF;
      tick;
      checkOutput("lat_hi_write", 32'({BUS_WE, BUS_ADDR, BUSY, ACK}), 32'({1'b1, 8'hD0, 1'b1, 2'b00}));
      tick;
      checkOutput("lat_lo_write", 32'({BUS_WE, BUS_ADDR, BUSY, ACK}), 32'({1'b1, 8'hD1, 1'b0, 2'b01}));
      REQ = 2'b00;
      tick;
      checkOutput("lat_idle", 32'({BUS_WE, ACK, BUSY}), 32'd0);
      checkOutput("lat_sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();

      for (int i = 0; i < 5; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Both requesters pending: grants alternate 0,1,0, each writing both bytes.
      tick;
      VALUE0 = 16'hAAAA;
      VALUE1 = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         sb.push_back(wr_t'{addr: 8'hD0, data: (alt_exp[i] == 2'b01 ? 8'hAA : 8'h55), ack: 2'b00});
         sb.push_back(wr_t'{addr: 8'hD1, data: (alt_exp[i] == 2'b01 ? 8'hAA : 8'h55), ack: alt_exp[i]});
      end
      REQ = 2'b11;
      for (int i = 0; i < 3; i++) begin
         waitAck(12, seen, cyc);
         if (i == 2) REQ = 2'b00;
         checkOutput($sformatf("alt_ack%0d", i), 32'(seen), 32'(alt_exp[i]));
      end
      checkOutput("alt_sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();

      // Shadow invalidation forces a full rewrite of an unchanged value.
      v = '{2'b10, 16'h0000, 16'h1299, 2'b10, 1'b1, 1'b1, 8'h12, 8'h99, 3};
      applyStimulus(v, "inv_pre");
      v = '{2'b10, 16'h0000, 16'h1299, 2'b10, 1'b0, 1'b0, 8'h00, 8'h00, 1};
      applyStimulus(v, "inv_skip");
      tick;
      INVALIDATE = 1'b1;
      tick;
      INVALIDATE = 1'b0;
      v = '{2'b10, 16'h0000, 16'h1299, 2'b10, 1'b1, 1'b1, 8'h12, 8'h99, 3};
      applyStimulus(v, "inv_post");

      // Bus stalls in both write states.
      tick;
      BUS_FREE = 1'b0;
      VALUE0   = 16'h7788;
      sb.push_back(wr_t'{addr: 8'hD0, data: 8'h77, ack: 2'b00});
      sb.push_back(wr_t'{addr: 8'hD1, data: 8'h88, ack: 2'b01});
      REQ = 2'b01;
      tick;
      for (int i = 0; i < 3; i++) begin
         tick;
         checkOutput($sformatf("stall_hi%0d", i), 32'({BUS_WE, BUSY}), 32'b01);
      end
      BUS_FREE = 1'b1;
      tick;
      checkOutput("stall_hi_resume", 32'({BUS_WE, BUS_ADDR}), 32'({1'b1, 8'hD0}));
      BUS_FREE = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick;
         checkOutput($sformatf("stall_lo%0d", i), 32'({BUS_WE, ACK}), 32'd0);
      end
      BUS_FREE = 1'b1;
      tick;
      checkOutput("stall_lo_resume", 32'({BUS_WE, BUS_ADDR, ACK}), 32'({1'b1, 8'hD1, 2'b01}));
      REQ = 2'b00;
      checkOutput("stall_sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();

      // Reset while in WR_LO: no low write, no ACK, shadow forgotten.
      tick;
      VALUE1 = 16'h4321;
      sb.push_back(wr_t'{addr: 8'hD0, data: 8'h43, ack: 2'b00});
      REQ = 2'b10;
      tick;
      tick;
      RESET = 1'b1;
      REQ   = 2'b00;
      tick;
      checkOutput("midreset_outputs", 32'({BUS_WE, BUS_ADDR, BUS_DATA, ACK, BUSY}), 32'd0);
      RESET = 1'b0;
      checkOutput("midreset_sb_drained", 32'(sb.size()), 32'd0);
      sb.delete();
      v = '{2'b10, 16'h0000, 16'h4321, 2'b10, 1'b1, 1'b1, 8'h43, 8'h21, 3};
      applyStimulus(v, "post_reset");

      // Instance without skipping rewrites both bytes every time.
      runNoSkip(16'h1111, "noskip_a");
      runNoSkip(16'h1111, "noskip_b");

      tick;
      checkOutput("final_sb_empty", 32'(sb.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/seg7_write_arbiter.md
Name: seg7_write_arbiter

Overview:
- Bus master that shares the memory-mapped 7-segment display peripheral (high byte at Seg7BaseAddress, low byte at Seg7BaseAddress+1) between two hardware requesters, e.g. the mouse X/Y status path and a debug source.
- Arbitrates round-robin, latches the winner's 16-bit value and issues one-cycle byte writes on the 8-bit write bus.
- Writes only when the external bus grant (BUS_FREE) is high.
- Optionally skips bytes that already match a shadow copy of the displayed value.

Parameters:
- Seg7BaseAddress, 8'hD0, address of the high byte; the low byte is at +1.
- SKIP_UNCHANGED, 1, 1 = suppress writes of bytes equal to a valid shadow; 0 = always write both bytes.

Ports:
- CLK  in  1  system clock; all logic on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- REQ  in  2  per-requester update request; level, held until ACK.
- VALUE0  in  16  requester 0 value; sampled only at grant.
- VALUE1  in  16  requester 1 value; sampled only at grant.
- ACK  out  2  one-cycle completion pulse per requester; registered.
- INVALIDATE  in  1  pulse; marks the shadow unknown (another master wrote the display).
- BUS_FREE  in  1  1 = this block may drive a write this cycle.
- BUS_ADDR  out  8  write address; registered.
- BUS_DATA  out  8  write data; registered.
- BUS_WE  out  1  write strobe, one cycle per byte; registered.
- BUSY  out  1  1 in any state other than IDLE.

Behaviour:
- Reset: state IDLE; BUS_ADDR=0, BUS_DATA=0, BUS_WE=0, ACK=0, BUSY=0; shadow=0 with shadow_valid=0; rr pointer last=1, so requester 0 wins the first tie. A reset mid-transaction aborts the transaction with no ACK.
- Outputs are default-low each cycle. BUS_WE, BUS_ADDR and BUS_DATA hold the last value, except that BUS_WE deasserts after one cycle. BUS_WE is never high for two consecutive cycles on the same address.
- IDLE, on an edge where masked REQ != 0:
  - Mask: a requester whose ACK is currently 1 is ignored.
  - Winner selection: if one requester is eligible, it wins. If both are eligible, the one that is not `last` wins. `last` updates to the winner.
  - Latch the winner's VALUE into hold and set the winner index.
  - Compute needs: need_hi = !SKIP_UNCHANGED | !shadow_valid | hold[15:8]!=shadow[15:8]; need_lo likewise for [7:0].
  - Next state: need_hi -> WR_HI; else need_lo -> WR_LO; else ACK[winner]=1 at this edge and stay in IDLE (zero-write completion).
- WR_HI:
  - Edge with BUS_FREE=0: stall; BUS_WE=0; no change.
  - Edge with BUS_FREE=1: drive BUS_WE=1, BUS_ADDR=Seg7BaseAddress, BUS_DATA=hold[15:8]; shadow[15:8]<=hold[15:8].
  - Then: need_lo -> WR_LO; else ACK[winner]=1 and go to IDLE.
- WR_LO:
  - Edge with BUS_FREE=0: stall.
  - Edge with BUS_FREE=1: drive BUS_WE=1, BUS_ADDR=Seg7BaseAddress+1, BUS_DATA=hold[7:0]; shadow[7:0]<=hold[7:0]; ACK[winner]=1; go to IDLE.
- Latency with BUS_FREE held at 1, REQ sampled at edge k:
  - High write visible in cycle k+2.
  - Low write plus ACK visible in cycle k+3.
  - The next grant can occur at edge k+3, so the next high write is visible in cycle k+5.
- shadow_valid:
  - Set at the ACK edge of any transaction that wrote both bytes, or that was skipped while shadow_valid=1.
  - Cleared by INVALIDATE. INVALIDATE wins over a same-edge set.
  - An INVALIDATE mid-transaction does not alter the current plan.
- VALUE changes after grant are ignored. REQ dropped before ACK does not cancel the transaction.

Decomposition:
- Package seg7_arb_pkg contains:
  - state encoding IDLE / WR_HI / WR_LO;
  - HI_OFFSET=0 and LO_OFFSET=1;
  - NUM_REQ=2.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin picker (inputs: req, last; outputs: grant index and valid). The pointer register stays in the top module.

Test Plan:
- Reset, then REQ=01, VALUE0=16'h1234, BUS_FREE=1 -> cycle k+2 shows WE, D0, 12; cycle k+3 shows WE, D1, 34 with ACK=01; BUSY high for 2 cycles.
- Both requesters pending: REQ=11 held with VALUE0=16'hAAAA and VALUE1=16'h5555 -> grants alternate 0,1,0. Each transaction writes both bytes, and each ACK appears only on the served requester.
- After 16'h1234 is displayed, requester 1 sends 16'h1299 -> only the D1 write (data 99) occurs, with ACK in the same cycle. Then 16'h1299 again -> no BUS_WE and ACK 1 cycle after grant.
- INVALIDATE pulse, then resend 16'h1299 -> both D0 and D1 are written. With SKIP_UNCHANGED=0, every request writes both bytes.
- BUS_FREE=0 for 3 cycles during WR_HI, then 2 cycles during WR_LO -> no BUS_WE while low; writes resume on the first free edge with correct address and data; ACK delayed accordingly.
- RESET asserted in WR_LO -> no low write and no ACK; all outputs 0 the next cycle; the next request writes both bytes because the shadow is invalid.
